// File: rtl/linebuf_ctrl.sv
// Sequencer for a three-bank line buffer: tracks col/row, rotates the write bank, and emits window strobes and bank selects.
// Write controls are combinational in the accept cycle; window outputs follow one cycle later, aligned with bank read data.
// No backpressure: every in_valid pixel is accepted, one per cycle, with no dead cycles at row or frame wrap.
module linebuf_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int LENGTH     = 100,
  parameter int HEIGHT     = 64,
  parameter int ROW_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  frame_start,
  output logic                  wr_en,
  output logic [1:0]            wr_bank,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  out_valid,
  output logic [1:0]            sel_top,
  output logic [1:0]            sel_mid,
  output logic [ADDR_WIDTH-1:0] out_col,
  output logic [ROW_WIDTH-1:0]  out_row,
  output logic                  line_done,
  output logic                  frame_done
);

  logic [ADDR_WIDTH-1:0] col, cur_col;
  logic [ROW_WIDTH-1:0]  row, cur_row;
  logic [1:0]            bank, cur_bank;
  logic                  last_col, last_row;

  function automatic logic [1:0] inc3(input logic [1:0] b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

  // frame_start makes this cycle behave as the first pixel of a fresh frame
  always_comb begin
    cur_col  = frame_start ? '0 : col;
    cur_row  = frame_start ? '0 : row;
    cur_bank = frame_start ? 2'd0 : bank;
    last_col = (cur_col == ADDR_WIDTH'(LENGTH - 1));
    last_row = (cur_row == ROW_WIDTH'(HEIGHT - 1));
  end

  assign wr_en   = in_valid & ~rst;
  assign wr_bank = rst ? 2'd0 : cur_bank;
  assign wr_addr = rst ? '0 : cur_col;
  assign rd_addr = wr_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      bank       <= 2'd0;
      out_valid  <= 1'b0;
      sel_top    <= 2'd0;
      sel_mid    <= 2'd0;
      out_col    <= '0;
      out_row    <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
    end else if (in_valid) begin
      if (!last_col) begin
        col  <= cur_col + ADDR_WIDTH'(1);
        row  <= cur_row;
        bank <= cur_bank;
      end else if (!last_row) begin
        col  <= '0;
        row  <= cur_row + ROW_WIDTH'(1);
        bank <= inc3(cur_bank);
      end else begin
        // HEIGHT need not be a multiple of 3, so the bank restarts explicitly
        col  <= '0;
        row  <= '0;
        bank <= 2'd0;
      end
      out_valid  <= (cur_row >= ROW_WIDTH'(2));
      sel_top    <= inc3(cur_bank);
      sel_mid    <= inc3(inc3(cur_bank));
      out_col    <= cur_col;
      out_row    <= cur_row;
      line_done  <= last_col;
      frame_done <= last_col & last_row;
    end else begin
      if (frame_start) begin
        col  <= '0;
        row  <= '0;
        bank <= 2'd0;
      end
      out_valid  <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Scoreboard bench for linebuf_ctrl with HEIGHT=4 so frame wrap is reachable in a short run.
module tb_linebuf_ctrl;
  localparam int L  = 100;
  localparam int H  = 4;
  localparam int AW = 7;
  localparam int RW = 7;

  logic          clk = 1'b0;
  logic          rst, in_valid, frame_start;
  logic          wr_en, out_valid, line_done, frame_done;
  logic [1:0]    wr_bank, sel_top, sel_mid;
  logic [AW-1:0] wr_addr, rd_addr, out_col;
  logic [RW-1:0] out_row;

  always #5 clk = ~clk;

  linebuf_ctrl #(.ADDR_WIDTH(AW), .LENGTH(L), .HEIGHT(H), .ROW_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .out_valid(out_valid), .sel_top(sel_top), .sel_mid(sel_mid),
    .out_col(out_col), .out_row(out_row),
    .line_done(line_done), .frame_done(frame_done)
  );

  typedef struct packed {
    logic          v;
    logic [1:0]    top;
    logic [1:0]    mid;
    logic [AW-1:0] col;
    logic [RW-1:0] row;
    logic          ld;
    logic          fd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   n     = 0;   // pixel index within the current frame

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Expected window output for a pixel at frame index n: row r lives in bank r%3.
  task automatic step(input logic v, input logic fs);
    int c, r;
    @(negedge clk);
    in_valid    = v;
    frame_start = fs;
    if (fs) n = 0;
    #1;
    c = n % L;
    r = n / L;
    if (v) begin
      chk("wr_en", wr_en, 1);
      chk("wr_bank", wr_bank, r % 3);
      chk("wr_addr", wr_addr, c);
      chk("rd_addr", rd_addr, c);
      if (r >= 2 || c == L - 1)
        q.push_back('{v: (r >= 2), top: 2'((r + 1) % 3), mid: 2'((r + 2) % 3),
                      col: AW'(c), row: RW'(r), ld: (c == L - 1),
                      fd: (c == L - 1 && r == H - 1)});
      n = (n + 1) % (L * H);
    end else begin
      chk("wr_en_idle", wr_en, 0);
    end
  endtask

  task automatic do_reset(input int cycles, input logic iv);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      rst         = 1'b1;
      in_valid    = iv;
      frame_start = 1'b0;
      n           = 0;
      #1;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_bank", wr_bank, 0);
      chk("rst_wr_addr", wr_addr, 0);
    end
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel_top", sel_top, 0);
    chk("rst_sel_mid", sel_mid, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_frame_done", frame_done, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a window or row/frame strobe, match it against the queue.
  always @(negedge clk) begin
    if (out_valid || line_done || frame_done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got out_valid=%0d line_done=%0d col=%0d row=%0d, expected none (t=%0t)",
                 out_valid, line_done, out_col, out_row, $time);
      end else begin
        mon_e = q.pop_front();
        chk("out_valid", out_valid, mon_e.v);
        chk("sel_top", sel_top, mon_e.top);
        chk("sel_mid", sel_mid, mon_e.mid);
        chk("out_col", out_col, mon_e.col);
        chk("out_row", out_row, mon_e.row);
        chk("line_done", line_done, mon_e.ld);
        chk("frame_done", frame_done, mon_e.fd);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    do_reset(3, 1'b1);

    // Continuous 300 pixels, then finish the frame and refill rows 0..1 of the next
    for (int i = 0; i < 600; i++) step(1'b1, 1'b0);

    // Gapped row 2
    for (int i = 0; i < L; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end

    // New frame, then abandon it at row 2 col 37
    step(1'b1, 1'b1);
    for (int i = 0; i < 236; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 349; i++) step(1'b1, 1'b0);

    // Mid-row-3 reset, then two fill rows before windows resume
    do_reset(1, 1'b0);
    for (int i = 0; i < 210; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
